// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one external up-counter between two requesters.
// Optional RUN-state watchdog enabled by defining CNT_SCHED_TIMEOUT_EN.
module counter_scheduler #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             abort,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy
);

  // state | meaning
  // IDLE  | arbitrate pending requests
  // CLEAR | clear shared counter for one cycle
  // RUN   | count until cnt_q matches latched target
  // DONE  | pulse done to the winner, then release grant
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_lat;
  logic             last_gnt;
  logic             win;
  logic             match;
  logic             to_hit;

  assign match = (cnt_q == tgt_lat);

  // On a tie the requester not served last time wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_gnt;
      default: win = 1'b0;
    endcase
  end

`ifdef CNT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          abort_q;

  assign to_hit = (state == RUN) && (tcnt == TW'(TIMEOUT - 1));
  assign abort  = abort_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt    <= '0;
      abort_q <= 1'b0;
    end else begin
      if (state == CLEAR)
        tcnt <= '0;
      else if (state == RUN)
        tcnt <= tcnt + 1'b1;
      abort_q <= (state == RUN) && to_hit && !match;
    end
  end
`else
  assign to_hit = 1'b0;
  assign abort  = 1'b0;
`endif

  assign busy    = (state != IDLE);
  assign cnt_clr = (state == CLEAR);
  assign cnt_en  = (state == RUN) && !match && !to_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      done     <= 2'b00;
      tgt_lat  <= '0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          if (req != 2'b00) begin
            gnt     <= win ? 2'b10 : 2'b01;
            tgt_lat <= win ? tgt1 : tgt0;
            state   <= CLEAR;
          end
        end
        CLEAR: state <= RUN;
        RUN: begin
          if (match || to_hit) begin
            done  <= gnt;
            state <= DONE;
          end
        end
        DONE: begin
          done     <= 2'b00;
          gnt      <= 2'b00;
          last_gnt <= gnt[1];
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler with a model of the shared up-counter attached.
module tb_counter_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] tgt0, tgt1;
  logic [3:0] cnt_q;
  logic [1:0] gnt, done;
  logic       abort, cnt_clr, cnt_en, busy;

  logic [3:0] cnt_m = 4'd0;
  logic       stuck = 1'b0;
  int nvec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_clr)     cnt_m <= 4'd0;
    else if (cnt_en) cnt_m <= cnt_m + 4'd1;
  end
  assign cnt_q = stuck ? 4'd0 : cnt_m;

  counter_scheduler #(.WIDTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .tgt0(tgt0), .tgt1(tgt1), .cnt_q(cnt_q),
    .gnt(gnt), .done(done), .abort(abort), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("clr_en_overlap", int'(cnt_clr && cnt_en), 0);
    chk("gnt_onehot", int'($countones(gnt) <= 1), 1);
    chk("done_without_gnt", int'(done & ~gnt), 0);
  end

  // Called at an IDLE negedge with inputs already applied; returns at the IDLE negedge after DONE.
  task automatic run_txn(input string nm, input int w, input int cq, input int len,
                         input int en, input int ab, input bit perturb);
    int glen = 0, nen = 0, nclr = 0, bad = 0;
    bit got = 1'b0;
    logic [1:0] oh;
    oh = (w != 0) ? 2'b10 : 2'b01;
    for (int i = 1; i <= 64 && !got; i++) begin
      @(negedge clk);
      if (i == 1) chk({nm, " gnt_at_grant"}, gnt, oh);
      if (gnt != 2'b00) glen++;
      if (gnt != oh) bad++;
      if (cnt_en) nen++;
      if (cnt_clr) nclr++;
      if (done != 2'b00) begin
        got = 1'b1;
        chk({nm, " done"}, done, oh);
        chk({nm, " cnt_q_at_done"}, cnt_q, cq);
        chk({nm, " abort_at_done"}, abort, ab);
      end
      if (perturb && i == 2) begin
        tgt0 = 4'd2;
        req  = 2'b00;
      end
    end
    if (!got) chk({nm, " done_never_seen"}, 0, 1);
    chk({nm, " gnt_cycles"}, glen, len);
    chk({nm, " en_cycles"}, nen, en);
    chk({nm, " clr_cycles"}, nclr, 1);
    chk({nm, " gnt_unstable"}, bad, 0);
    @(negedge clk);
    chk({nm, " idle_gnt"}, gnt, 0);
    chk({nm, " idle_busy"}, busy, 0);
    chk({nm, " idle_done"}, done, 0);
    chk({nm, " idle_abort"}, abort, 0);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] t0;
    logic [3:0] t1;
    int         w;
    int         t;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int seen, nbusy;
    tbl[0] = '{2'b11, 4'd2,  4'd3,  0, 2};
    tbl[1] = '{2'b11, 4'd2,  4'd3,  1, 3};
    tbl[2] = '{2'b11, 4'd2,  4'd3,  0, 2};
    tbl[3] = '{2'b11, 4'd2,  4'd3,  1, 3};
    tbl[4] = '{2'b01, 4'd5,  4'd3,  0, 5};
    tbl[5] = '{2'b10, 4'd5,  4'd0,  1, 0};
    tbl[6] = '{2'b01, 4'd15, 4'd0,  0, 15};
    tbl[7] = '{2'b11, 4'd7,  4'd1,  1, 1};
    tbl[8] = '{2'b10, 4'd7,  4'd15, 1, 15};
    tbl[9] = '{2'b11, 4'd0,  4'd9,  0, 0};

    rst = 1'b0; req = 2'b00; tgt0 = 4'd0; tgt1 = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst gnt", gnt, 0);
    chk("rst done", done, 0);
    chk("rst abort", abort, 0);
    chk("rst cnt_clr", cnt_clr, 0);
    chk("rst cnt_en", cnt_en, 0);
    chk("rst busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_req busy", busy, 0);

    for (int v = 0; v < 10; v++) begin
      req = tbl[v].req; tgt0 = tbl[v].t0; tgt1 = tbl[v].t1;
      run_txn($sformatf("vec%0d", v), tbl[v].w, tbl[v].t, tbl[v].t + 3, tbl[v].t, 0, 1'b0);
    end

    // Target and request changes after grant are ignored.
    req = 2'b01; tgt0 = 4'd9; tgt1 = 4'd0;
    run_txn("tgt_change", 0, 9, 12, 9, 0, 1'b1);

    // Reset in the 4th RUN cycle discards the run and restores the tie-break.
    req = 2'b01; tgt0 = 4'd15;
    repeat (5) @(negedge clk);
    chk("midrst busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst gnt", gnt, 0);
    chk("midrst cnt_en", cnt_en, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    rst = 1'b1; req = 2'b11; tgt0 = 4'd1; tgt1 = 4'd2;
    run_txn("after_rst", 0, 1, 4, 1, 0, 1'b0);

    // Counter stuck at zero.
    req = 2'b01; tgt0 = 4'd4; stuck = 1'b1;
`ifdef CNT_SCHED_TIMEOUT_EN
    run_txn("timeout", 0, 0, 10, 7, 1, 1'b0);
    req = 2'b00; stuck = 1'b0;
`else
    seen = 0; nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done != 2'b00 || abort) seen++;
      if (!busy) nbusy++;
    end
    chk("stuck not_busy_cycles", nbusy, 0);
    chk("stuck done_or_abort", seen, 0);
    chk("stuck gnt_held", gnt, 1);
    rst = 1'b0; req = 2'b00; stuck = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("stuck recover busy", busy, 0);
`endif
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
